// File: rtl/baud_prescaler.sv
// ============================================================================
// baud_prescaler: runtime-programmable clock prescaler and UART baud-tick
// generator (oversample tick, bit tick, square-wave clk_div).
// Revision: 1.0
// ============================================================================
`default_nettype none

module baud_prescaler #(
  parameter int CNT_W       = 16,
  parameter int OVS         = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic             src_clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_val_i,
  input  logic             div_load_i,
  input  logic             resync_i,
  output logic             tick_ovs_o,
  output logic             tick_bit_o,
  output logic             clk_div_o,
  output logic             div_ack_o,
  output logic             div_err_o
);

  localparam int                c_OCNT_W    = $clog2(OVS);
  localparam logic [c_OCNT_W-1:0] c_OCNT_LAST = c_OCNT_W'(OVS - 1);
  localparam logic [c_OCNT_W-1:0] c_OCNT_MID  = c_OCNT_W'(OVS / 2);
  localparam logic [CNT_W-1:0]    c_DIV_RST   = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    div_q,  div_d;
  logic [CNT_W-1:0]    divp_q, divp_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic [c_OCNT_W-1:0] ocnt_q, ocnt_d;
  logic                tick_ovs_q, tick_ovs_d;
  logic                tick_bit_q, tick_bit_d;
  logic                clk_div_q,  clk_div_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic w_wrap;
  logic w_apply;

  // Resync suppresses the wrap, so a pending divisor cannot apply on a
  // resync edge unless counting is disabled.
  assign w_wrap  = en_i && !resync_i && (cnt_q == (div_q - CNT_W'(1)));
  assign w_apply = pend_q && (w_wrap || !en_i);

  always_comb begin
    div_d      = div_q;
    divp_d     = divp_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    ocnt_d     = ocnt_q;
    clk_div_d  = clk_div_q;
    tick_ovs_d = 1'b0;
    tick_bit_d = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    if (resync_i) begin
      cnt_d  = '0;
      ocnt_d = c_OCNT_MID;
    end else if (en_i) begin
      if (w_wrap) begin
        cnt_d      = '0;
        tick_ovs_d = 1'b1;
        clk_div_d  = ~clk_div_q;
        if (ocnt_q == c_OCNT_LAST) begin
          ocnt_d     = '0;
          tick_bit_d = 1'b1;
        end else begin
          ocnt_d = ocnt_q + c_OCNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (w_apply) begin
      div_d  = divp_q;
      cnt_d  = '0;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end

    // A load landing on the application edge becomes the next pending value.
    if (div_load_i) begin
      if (div_val_i != '0) begin
        divp_d = div_val_i;
        pend_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk_i) begin
    if (!rst_n_i) begin
      div_q      <= c_DIV_RST;
      divp_q     <= c_DIV_RST;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      ocnt_q     <= '0;
      tick_ovs_q <= 1'b0;
      tick_bit_q <= 1'b0;
      clk_div_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      divp_q     <= divp_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      ocnt_q     <= ocnt_d;
      tick_ovs_q <= tick_ovs_d;
      tick_bit_q <= tick_bit_d;
      clk_div_q  <= clk_div_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign tick_ovs_o = tick_ovs_q;
  assign tick_bit_o = tick_bit_q;
  assign clk_div_o  = clk_div_q;
  assign div_ack_o  = ack_q;
  assign div_err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_baud_prescaler.sv
// ============================================================================
// tb_baud_prescaler: directed self-checking bench for baud_prescaler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_baud_prescaler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
  logic        resync;
  logic        tick_ovs;
  logic        tick_bit;
  logic        clk_div;
  logic        div_ack;
  logic        div_err;

  int npass  = 0;
  int ntotal = 0;

  baud_prescaler #(
    .CNT_W      (16),
    .OVS        (16),
    .DEFAULT_DIV(27)
  ) dut (
    .src_clk_i (clk),
    .rst_n_i   (rst_n),
    .en_i      (en),
    .div_val_i (div_val),
    .div_load_i(div_load),
    .resync_i  (resync),
    .tick_ovs_o(tick_ovs),
    .tick_bit_o(tick_bit),
    .clk_div_o (clk_div),
    .div_ack_o (div_ack),
    .div_err_o (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; div_val = 16'd5; div_load = 1'b1; resync = 1'b0;
    repeat (3) step();
    div_load = 1'b0;
    step();
    ntotal++;
    if ({tick_ovs, tick_bit, clk_div, div_ack, div_err} !== 5'b0)
      $display("FAIL reset_outputs got=%b want=00000",
               {tick_ovs, tick_bit, clk_div, div_ack, div_err});
    else npass++;
  endtask

  task automatic test_default_period();
    int first, n_ovs, n_bit, bad_ovs, bad_bit, bad_clk;
    first = 0; n_ovs = 0; n_bit = 0; bad_ovs = 0; bad_bit = 0; bad_clk = 0;
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 864; i++) begin
      step();
      if (tick_ovs && first == 0) first = i;
      if (tick_ovs) n_ovs++;
      if (tick_bit) n_bit++;
      if (tick_ovs !== (i % 27 == 0)) bad_ovs++;
      if (tick_bit !== (i % 432 == 0)) bad_bit++;
      if (clk_div !== 1'((i / 27) % 2)) bad_clk++;
    end
    ntotal++;
    if (first !== 27) $display("FAIL first_tick got=%0d want=27", first); else npass++;
    ntotal++;
    if (n_ovs !== 32) $display("FAIL ovs_count got=%0d want=32", n_ovs); else npass++;
    ntotal++;
    if (bad_ovs !== 0) $display("FAIL ovs_period27 bad=%0d want=0", bad_ovs); else npass++;
    ntotal++;
    if (n_bit !== 2 || bad_bit !== 0)
      $display("FAIL bit_period432 count=%0d bad=%0d want count=2 bad=0", n_bit, bad_bit);
    else npass++;
    ntotal++;
    if (bad_clk !== 0) $display("FAIL clk_div_period54 bad=%0d want=0", bad_clk); else npass++;
  endtask

  task automatic test_load_mid_period();
    int first, n_ack, ack_at, bad;
    first = 0; n_ack = 0; ack_at = 0; bad = 0;
    repeat (10) step();           // cnt = 10
    div_val = 16'd4; div_load = 1'b1;
    step();
    div_load = 1'b0;
    if (tick_ovs || div_ack) bad++;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (tick_ovs && first == 0) first = i;
      if (div_ack) begin n_ack++; ack_at = i; end
    end
    ntotal++;
    if (first !== 16 || bad !== 0)
      $display("FAIL load_old_period got=%0d want=16", first);
    else npass++;
    ntotal++;
    if (n_ack !== 1 || ack_at !== 16)
      $display("FAIL load_ack_coincide count=%0d at=%0d want count=1 at=16", n_ack, ack_at);
    else npass++;
    bad = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (tick_ovs !== (i % 4 == 0)) bad++;
      if (div_ack) bad++;
    end
    ntotal++;
    if (bad !== 0) $display("FAIL load_new_period4 bad=%0d want=0", bad); else npass++;
  endtask

  task automatic test_div_err();
    int bad_ovs, bad_ack, bad_err;
    bad_ovs = 0; bad_ack = 0; bad_err = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 1) begin div_val = 16'd0; div_load = 1'b1; end
      step();
      div_load = 1'b0;
      if (tick_ovs !== (i % 4 == 0)) bad_ovs++;
      if (div_ack !== 1'b0) bad_ack++;
      if (div_err !== (i == 1)) bad_err++;
    end
    ntotal++;
    if (bad_err !== 0) $display("FAIL err_pulse bad=%0d want=0", bad_err); else npass++;
    ntotal++;
    if (bad_ovs !== 0) $display("FAIL err_div_unchanged bad=%0d want=0", bad_ovs); else npass++;
    ntotal++;
    if (bad_ack !== 0) $display("FAIL err_no_ack bad=%0d want=0", bad_ack); else npass++;
  endtask

  task automatic test_enable_hold();
    logic saved;
    int   bad, first;
    bad = 0; first = 0;
    repeat (2) step();            // cnt = 2
    saved = clk_div;
    en = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (tick_ovs || tick_bit || clk_div !== saved) bad++;
    end
    ntotal++;
    if (bad !== 0) $display("FAIL hold_frozen bad=%0d want=0", bad); else npass++;
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (tick_ovs && first == 0) first = i;
    end
    ntotal++;
    if (first !== 2) $display("FAIL hold_resume got=%0d want=2", first); else npass++;
    ntotal++;
    if (clk_div !== ~saved) $display("FAIL hold_clk_toggle got=%b want=%b", clk_div, ~saved);
    else npass++;
    repeat (2) step();            // realign to cnt = 0
  endtask

  task automatic test_resync();
    int bad_ovs, bad_bit;
    bad_ovs = 0; bad_bit = 0;
    repeat (3) step();            // cnt = 3: this edge would otherwise wrap
    resync = 1'b1;
    step();
    resync = 1'b0;
    ntotal++;
    if (tick_ovs !== 1'b0 || tick_bit !== 1'b0)
      $display("FAIL resync_priority got=%b%b want=00", tick_ovs, tick_bit);
    else npass++;
    for (int i = 1; i <= 96; i++) begin
      step();
      if (tick_ovs !== (i % 4 == 0)) bad_ovs++;
      if (tick_bit !== (i == 32 || i == 96)) bad_bit++;
    end
    ntotal++;
    if (bad_bit !== 0) $display("FAIL resync_bit_32_64 bad=%0d want=0", bad_bit); else npass++;
    ntotal++;
    if (bad_ovs !== 0) $display("FAIL resync_ovs bad=%0d want=0", bad_ovs); else npass++;
  endtask

  task automatic test_div1();
    logic prev;
    int   bad_ovs, bad_bit, bad_clk;
    bad_ovs = 0; bad_bit = 0; bad_clk = 0;
    en = 1'b0; div_val = 16'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    ntotal++;
    if (div_ack !== 1'b0) $display("FAIL div1_early_ack got=%b want=0", div_ack); else npass++;
    step();
    ntotal++;
    if (div_ack !== 1'b1) $display("FAIL div1_ack_disabled got=%b want=1", div_ack); else npass++;
    en = 1'b1;
    prev = clk_div;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (tick_ovs !== 1'b1) bad_ovs++;
      if (tick_bit !== (i % 16 == 0)) bad_bit++;
      if (clk_div !== ~prev) bad_clk++;
      prev = clk_div;
    end
    ntotal++;
    if (bad_ovs !== 0) $display("FAIL div1_ovs bad=%0d want=0", bad_ovs); else npass++;
    ntotal++;
    if (bad_bit !== 0) $display("FAIL div1_bit16 bad=%0d want=0", bad_bit); else npass++;
    ntotal++;
    if (bad_clk !== 0) $display("FAIL div1_clk_toggle bad=%0d want=0", bad_clk); else npass++;
  endtask

  task automatic test_reset_pending();
    int bad_ovs, bad_ack;
    bad_ovs = 0; bad_ack = 0;
    div_val = 16'd9; div_load = 1'b1;
    step();
    div_load = 1'b0; rst_n = 1'b0;
    step();
    ntotal++;
    if ({tick_ovs, tick_bit, clk_div, div_ack, div_err} !== 5'b0)
      $display("FAIL midrun_reset_outputs got=%b want=00000",
               {tick_ovs, tick_bit, clk_div, div_ack, div_err});
    else npass++;
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (tick_ovs !== (i % 27 == 0)) bad_ovs++;
      if (div_ack !== 1'b0) bad_ack++;
    end
    ntotal++;
    if (bad_ovs !== 0) $display("FAIL reset_default_div bad=%0d want=0", bad_ovs); else npass++;
    ntotal++;
    if (bad_ack !== 0) $display("FAIL reset_pending_dropped bad=%0d want=0", bad_ack); else npass++;
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_load_mid_period();
    test_div_err();
    test_enable_hold();
    test_resync();
    test_div1();
    test_reset_pending();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/baud_prescaler.md
# baud_prescaler

Programmable clock prescaler and UART baud-tick generator: the parametrised successor of the fixed-divide `Prescaler`. Divides `src_clk` by a runtime-loadable divisor to produce a one-cycle oversample tick, a one-cycle bit tick every OVS oversample ticks, and a square-wave `clk_div`. Divisor changes are glitch-free, and a resync input aligns bit ticks to mid-bit for the UART receiver. Sits between the system clock and the UART TX/RX engines.

## Interface
- `CNT_W`, 16: width of divisor and divide counter.
- `OVS`, 16: oversample ticks per bit tick; legal range 2..256, even.
- `DEFAULT_DIV`, 27: divisor loaded at reset; must be in 1..2^CNT_W-1.
- `src_clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `en`  in  1  count enable; when low, counters and `clk_div` hold.
- `div_val`  in  CNT_W  new divisor value.
- `div_load`  in  1  one-cycle request to load `div_val`.
- `resync`  in  1  one-cycle request to realign the bit phase (RX start-bit edge).
- `tick_ovs`  out  1  one-cycle oversample tick.
- `tick_bit`  out  1  one-cycle bit tick, coincident with a `tick_ovs`.
- `clk_div`  out  1  square wave, period 2×divisor cycles while enabled.
- `div_ack`  out  1  one-cycle pulse when a pending divisor takes effect.
- `div_err`  out  1  one-cycle pulse when `div_load` carries `div_val` = 0.

## Operation
- Registers: `div_r` (active divisor), `div_p` + `pend` (pending divisor), `cnt` (0..div_r-1), `ocnt` (0..OVS-1), and all outputs. Every output is registered.
- Reset (`rst_n`=0 at an edge):
  - `div_r`=DEFAULT_DIV, `cnt`=0, `ocnt`=0, `pend`=0.
  - `tick_ovs`=`tick_bit`=`clk_div`=`div_ack`=`div_err`=0.
  - Reset overrides every other input in the same cycle.
- Divide counter, on an edge with `en`=1:
  - If `cnt`=div_r-1: wrap `cnt` to 0, set `tick_ovs`=1, toggle `clk_div`.
  - Otherwise: increment `cnt`, `tick_ovs`=0.
  - With `en`=0: hold `cnt`, `ocnt` and `clk_div`; `tick_ovs`=`tick_bit`=0.
- Bit counter: advances only on wrap edges.
  - At `ocnt`=OVS-1 it wraps to 0 and sets `tick_bit`=1 in the same cycle as `tick_ovs`.
  - Otherwise `tick_bit`=0.
- Divisor load:
  - `div_load` with `div_val`≠0: `div_p`←`div_val`, `pend`←1. A later load before application overwrites `div_p`; last value wins.
  - `div_load` with `div_val`=0: `div_err`=1 for one cycle; `div_p` and `pend` are unchanged.
  - Application point: the next wrap edge, or the next edge while `en`=0.
  - On application: `div_r`←`div_p`, `cnt`←0, `pend`←0, `div_ack`=1 for one cycle.
  - `ocnt` and `clk_div` are not disturbed.
  - No `tick_ovs` period is ever shorter than min(old, new) divisor.
- Resync, on the edge where `resync`=1:
  - `cnt`←0, `ocnt`←OVS/2, `tick_ovs`=`tick_bit`=0.
  - The first following `tick_bit` falls mid-bit: OVS/2 oversample periods later.
  - `resync` has priority over the wrap in the same cycle. A pending load still applies at that edge if `en`=0, otherwise at the next wrap.
- Simultaneous `div_load` and application in the same cycle: the old `div_p` is applied, and the new value becomes pending.

## Timing
- With `en`=1 from the first edge after reset release, `tick_ovs` is high in the cycle after the div_r-th enabled edge. Ticks then repeat every div_r cycles.
- div_r=1: `tick_ovs` high every enabled cycle; `clk_div` toggles every cycle.
- `tick_bit` period is OVS×div_r cycles. `tick_bit` is never high without `tick_ovs`.
- `div_err` is high in the cycle after the bad `div_load` edge.
- `div_ack` is high in the cycle after the application edge. It coincides with `tick_ovs` when application happens on a wrap.
- Latency from `resync` edge to first `tick_bit`: (OVS/2)×div_r cycles with `en` held high.
- Counter width: `cnt` compares against div_r-1 in CNT_W bits. `ocnt` is ⌈log2 OVS⌉ bits.

## Test plan
- Reset, DEFAULT_DIV=27, OVS=16, `en`=1:
  - -> first `tick_ovs` 27 cycles after reset release, then every 27 cycles.
  - -> `tick_bit` every 432 cycles.
  - -> `clk_div` period 54.
- `div_load` `div_val`=4 mid-period (`cnt`=10):
  - -> current period still completes at 27.
  - -> `div_ack` coincides with that tick.
  - -> subsequent `tick_ovs` every 4 cycles.
- `div_load` `div_val`=0:
  - -> `div_err` one cycle.
  - -> divisor unchanged.
  - -> no `div_ack`.
- `en`=0 for 50 cycles mid-count:
  - -> no ticks.
  - -> `cnt`, `ocnt` and `clk_div` frozen.
  - -> counting resumes from the same `cnt`.
- `resync` with div_r=4, OVS=16:
  - -> next `tick_bit` exactly 32 cycles later, then every 64 cycles.
- div_r=1:
  - -> `tick_ovs` constantly high.
  - -> `tick_bit` every 16th cycle.
- `rst_n`=0 mid-operation with a pending load:
  - -> all outputs 0 next cycle.
  - -> `div_r`=DEFAULT_DIV.
  - -> pending load discarded.
